// File: rtl/seg_scan_driver_if.sv
// Purpose: bundles the display-value capture and scan-output signals of seg_scan_driver.
// Latency: pure wiring; no storage.
// Backpressure: none; load is a fire-and-forget strobe and scan outputs are always valid.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // datapath side: value to capture and its strobe
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;

  // decoder / anode side: current scan slot
  logic [3:0]              digit_hex;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_start;

  // producer of the hex value, consumer of the scan outputs
  modport master (
    output value,
    output load,
    input  digit_hex,
    input  anode_n,
    input  digit_idx,
    input  frame_start
  );

  // the scan driver itself
  modport slave (
    input  value,
    input  load,
    output digit_hex,
    output anode_n,
    output digit_idx,
    output frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexed 7-segment scan driver with tear-free shadow copy of the displayed value
//          (leading-zero blanking enabled by defining LEADING_ZERO_BLANK_EN).
// Latency: outputs registered, change only on a tick edge; load shows at the next frame boundary (<= 1 frame).
// Backpressure: none; load always accepted, last load before a frame boundary wins.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,      // 2..8
  parameter int REFRESH_DIV = 50000   // 2..2^20 cycles per digit slot
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ------------------------------------------------------------------
  // state
  // ------------------------------------------------------------------
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      pending;
  logic [VAL_W-1:0]      shadow;
  logic [3:0]            digit_hex_q;
  logic [NUM_DIGITS-1:0] anode_n_q;
  logic                  frame_start_q;

  // ------------------------------------------------------------------
  // next-state decode
  // ------------------------------------------------------------------
  logic                  tick;
  logic                  frame_wrap;
  logic [IDX_W-1:0]      idx_next;
  logic [VAL_W-1:0]      shadow_next;
  logic [3:0]            nibble_next;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [NUM_DIGITS-1:0] lead_zero;

  assign tick       = (cnt == CNT_LAST);
  assign frame_wrap = tick && (idx == IDX_LAST);
  assign idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // At the frame boundary a same-cycle load bypasses pending so the new
  // value is visible in the very frame that starts on this edge.
  assign shadow_next = frame_wrap ? (bus.load ? bus.value : pending) : shadow;

  // Select the nibble that becomes active on the tick edge. The decoder
  // downstream is combinational, so the nibble must come from the shadow
  // value that is valid for the new slot, not the one being replaced.
  always_comb begin
    nibble_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nibble_next = shadow_next[4*i +: 4];
      end
    end
  end

  // lead_zero[i] is set when nibbles i..top of the upcoming shadow are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (shadow_next[VAL_W-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (shadow_next[4*i +: 4] == 4'h0);
    end
  end

  // One-cold anode pattern for the new slot, with optional leading-zero blanking.
  always_comb begin
    anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      // Digit 0 is never blanked so a zero value still shows "0".
      anode_next[i] = !(idx_next == IDX_W'(i)) || ((i != 0) && lead_zero[i]);
`else
      anode_next[i] = !(idx_next == IDX_W'(i));
`endif
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  // Leading-zero chain is only consumed when blanking is built in.
  logic unused_lead_zero;
  assign unused_lead_zero = ^lead_zero;
`endif

  // ------------------------------------------------------------------
  // sequential logic
  // ------------------------------------------------------------------

  // Slot timer: free-running divider that fires one tick per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture register: the last load strobe wins until the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (bus.load) begin
      pending <= bus.value;
    end
  end

  // Shadow copy: only refreshed at a frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (frame_wrap) begin
      shadow <= shadow_next;
    end
  end

  // Scan position and registered outputs, all advanced together on a tick.
  // Reset parks idx on the last digit so the first tick lands on digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= IDX_LAST;
      digit_hex_q   <= '0;
      anode_n_q     <= '1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_wrap;
      if (tick) begin
        idx         <= idx_next;
        digit_hex_q <= nibble_next;
        anode_n_q   <= anode_next;
      end
    end
  end

  // ------------------------------------------------------------------
  // outputs
  // ------------------------------------------------------------------
  assign bus.digit_hex   = digit_hex_q;
  assign bus.anode_n     = anode_n_q;
  assign bus.digit_idx   = idx;
  assign bus.frame_start = frame_start_q;

endmodule
